// File: rtl/branch_resolve_bp_if.sv
// Decode-stage branch resolution bundle: fetch lookup, decode operands/flags, resolution results, perf counts.
// Latency: n/a (wiring only).
// Backpressure: none; the decode stall travels as the hazard signal.
interface branch_resolve_bp_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic            id_pred_taken;
    logic [XLEN-1:0] rs1_mod;
    logic [XLEN-1:0] rs2_mod;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [2:0]      funct3;
    logic            hazard;
    logic            branch_taken;
    logic            redirect;
    logic            redirect_to_target;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    modport master (
        output if_pc, id_valid, id_pc, id_pred_taken, rs1_mod, rs2_mod,
               branch, jal, jalr, funct3, hazard,
        input  if_pred_taken, branch_taken, redirect, redirect_to_target,
               perf_branches, perf_mispredicts
    );

    modport slave (
        input  if_pc, id_valid, id_pc, id_pred_taken, rs1_mod, rs2_mod,
               branch, jal, jalr, funct3, hazard,
        output if_pred_taken, branch_taken, redirect, redirect_to_target,
               perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_resolve_bp.sv
// Branch resolution with 2-bit bimodal predictor; raises redirect when the fetch prediction was wrong.
// Latency: resolve/redirect combinational (0 cycles); table and perf counters commit on the next edge.
// Backpressure: hazard=1 freezes all effects so a stalled instruction resolves once, when released.
module branch_resolve_bp #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter int          PC_LSB      = 2,
    parameter logic [31:0] PERF_RESET  = 32'd0
) (
    input logic             clk,
    input logic             rst_n,
    branch_resolve_bp_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             cond;
    logic             legal;
    logic             active;
    logic             taken;
    logic             mispredict;
    logic             upd;
    logic [31:0]      perf_br_q;
    logic [31:0]      perf_mis_q;
    logic             unused_pc_bits;

    assign rd_idx         = bus.if_pc[PC_LSB +: IDX_W];
    assign wr_idx         = bus.id_pc[PC_LSB +: IDX_W];
    assign unused_pc_bits = ^{bus.if_pc, bus.id_pc};

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (bus.funct3)
            3'b000:  cond = (bus.rs1_mod == bus.rs2_mod);
            3'b001:  cond = (bus.rs1_mod != bus.rs2_mod);
            3'b100:  cond = ($signed(bus.rs1_mod) <  $signed(bus.rs2_mod));
            3'b101:  cond = ($signed(bus.rs1_mod) >= $signed(bus.rs2_mod));
            3'b110:  cond = (bus.rs1_mod <  bus.rs2_mod);
            3'b111:  cond = (bus.rs1_mod >= bus.rs2_mod);
            default: legal = 1'b0;
        endcase
    end

    assign active     = bus.id_valid & ~bus.hazard;
    assign taken      = active & ((bus.branch & cond) | bus.jal | bus.jalr);
    // Covers both directions: missed jumps/taken branches and aliased taken predictions on non-branches.
    assign mispredict = active & (taken != bus.id_pred_taken);
    assign upd        = active & bus.branch & legal;

    assign bus.branch_taken       = taken;
    assign bus.redirect           = mispredict;
    assign bus.redirect_to_target = taken;
    assign bus.if_pred_taken      = bht[rd_idx][1];
    assign bus.perf_branches      = perf_br_q;
    assign bus.perf_mispredicts   = perf_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
            perf_br_q  <= PERF_RESET;
            perf_mis_q <= PERF_RESET;
        end else begin
            if (upd) begin
                if (cond) begin
                    if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
                end else begin
                    if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
                end
            end
            if (upd && perf_br_q != 32'hFFFF_FFFF) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (mispredict && perf_mis_q != 32'hFFFF_FFFF) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end
endmodule

// File: doc/branch_resolve_bp.md
# branch_resolve_bp

Parametrised branch resolution unit with an integrated 2-bit bimodal predictor, sitting in the decode stage alongside branchforward. It evaluates the conditional branch outcome and jal/jalr from forwarded operands. It compares that outcome with the prediction carried down from fetch and raises a redirect on mismatch. It trains a BHT_ENTRIES-deep table of saturating counters that fetch reads for the next prediction.

## Interface
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, counter table depth; power of two, 2 to 1024
- PC_LSB, 2, lowest PC bit used for indexing; IDX_W = log2(BHT_ENTRIES)
- clk  in  1  clock; everything samples on the rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch-stage PC for lookup
- if_pred_taken  out  1  prediction for if_pc; combinational read of the table
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  XLEN  decode-stage PC, used for the update index
- id_pred_taken  in  1  prediction that fetch made for this instruction
- rs1_mod, rs2_mod  in  XLEN  forwarded operands
- branch, jal, jalr  in  1  decoded control-op flags; at most one is set
- funct3  in  3  branch condition field
- hazard  in  1  stall; suppresses all effects this cycle
- branch_taken  out  1  actual outcome
- redirect  out  1  misprediction, so fetch must be redirected and IF flushed
- redirect_to_target  out  1  with redirect: 1 means go to target, 0 means go to id_pc+4
- perf_branches  out  32  resolved conditional branches
- perf_mispredicts  out  32  redirects issued

## Operation
- Condition decode on funct3:
  - 000 beq: operands equal.
  - 001 bne: operands not equal.
  - 100 blt: signed less-than.
  - 101 bge: not signed less-than.
  - 110 bltu: unsigned less-than.
  - 111 bgeu: not unsigned less-than.
  - 010 and 011 are illegal: the outcome is not-taken, there is no counter update and no perf count.
- Comparisons use the full XLEN width, with no truncation.
- active = id_valid & !hazard.
- branch_taken = active & ((branch & cond) | jal | jalr).
- redirect = active & (branch_taken != id_pred_taken). This covers:
  - jal/jalr predicted not-taken;
  - aliased non-control instructions predicted taken, which go to id_pc+4.
- redirect_to_target = branch_taken. This output is don't-care when redirect=0.
- Table: BHT_ENTRIES 2-bit counters.
  - Encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
  - Prediction is the counter MSB.
  - Read index = if_pc[PC_LSB +: IDX_W]; write index = id_pc[PC_LSB +: IDX_W].
- Update happens only when active & branch & funct3 is legal.
  - Taken: the counter increments, saturating at 11.
  - Not-taken: the counter decrements, saturating at 00.
  - jal/jalr never train the table.
- perf_branches increments under the same condition as the table update.
- perf_mispredicts increments on every redirect.
- Both perf counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Reset, asynchronous and immediate:
  - every counter goes to 01, so if_pred_taken=0;
  - both perf counters go to 0.
- branch_taken, redirect and redirect_to_target are combinational outputs with 0-cycle latency. With hazard=1 or id_valid=0 they are all 0.
- Table and perf updates commit on the rising edge after the resolving cycle.
- Same-cycle read and write to one index is read-before-write. if_pred_taken shows the old counter and sees the new value one cycle later.
- hazard held for N cycles: the same instruction is resolved once, on the first cycle with hazard=0. There is no double update.
- rst_n asserted mid-update: the edge update is lost and every entry reads 01 immediately.
- Index aliasing is permitted. Distinct PCs that share index bits share a counter.

## Test plan
- Reset: rst_n=0 → if_pred_taken=0 for all indices, perf_branches=0, perf_mispredicts=0, all decode outputs 0.
- Taken loop: beq with rs1=rs2=5 at id_pc=0x40, id_pred_taken follows if_pred_taken at if_pc=0x40.
  - Cycle 1 and cycle 2 each give redirect=1; the counter goes 01→10→11.
  - From cycle 3 onward, redirect=0 and branch_taken=1; perf_mispredicts=2 after 4 branches.
- Signed/unsigned: rs1=0xFFFF_FFFF, rs2=1.
  - blt → branch_taken=1; bltu → 0; bge → 0; bgeu → 1.
- Hazard: bne that is taken with hazard=1 for 3 cycles, then 0 → branch_taken=0 and redirect=0 while stalled, then exactly one counter update and perf_branches +1.
- Jumps and illegal encoding:
  - jal with id_pred_taken=0 → branch_taken=1, redirect=1, redirect_to_target=1, table unchanged.
  - branch with funct3=010 → branch_taken=0, perf_branches unchanged.
  - Non-control valid instruction with id_pred_taken=1 → redirect=1, redirect_to_target=0.
- Saturation and aliasing:
  - Four not-taken resolves at index 3 → counter stays 00.
  - id_pc=0x0C and id_pc=0x10C with BHT_ENTRIES=64 share one counter.
  - Preloaded perf_mispredicts=0xFFFF_FFFF plus one redirect stays 0xFFFF_FFFF.
